// File: rtl/sdp_bram_bytewr_pipe_if.sv
// Bundle of the write and read ports of sdp_bram_bytewr_pipe.
//   master : drives wren/bwren/wraddrs/wrdata and rden/rdaddrs; receives rddata/rdvalid/collision
//   slave  : the RAM side of the same signals
interface sdp_bram_bytewr_pipe_if #(
  parameter int unsigned NB_COL      = 128,
  parameter int unsigned COL_WIDTH   = 8,
  parameter int unsigned ADDRS_WIDTH = 12
);
  localparam int unsigned DataW = NB_COL * COL_WIDTH;

  logic                   wren;
  logic [NB_COL-1:0]      bwren;
  logic [ADDRS_WIDTH-1:0] wraddrs;
  logic [DataW-1:0]       wrdata;
  logic                   rden;
  logic [ADDRS_WIDTH-1:0] rdaddrs;
  logic [DataW-1:0]       rddata;
  logic                   rdvalid;
  logic                   collision;

  modport master (
    output wren, bwren, wraddrs, wrdata, rden, rdaddrs,
    input  rddata, rdvalid, collision
  );

  modport slave (
    input  wren, bwren, wraddrs, wrdata, rden, rdaddrs,
    output rddata, rdvalid, collision
  );
endinterface

// File: rtl/sdp_bram_bytewr_pipe.sv
// Simple dual-port block RAM, one clock, per-column write enables, 1- or 2-stage read pipeline
// with a valid flag, optional write-first forwarding and a same-address collision flag.
// Ports:
//   CLK    : clock, all state on rising edge
//   RESET  : asynchronous active-high reset of the read pipeline (memory contents are kept)
//   bus    : slave side of sdp_bram_bytewr_pipe_if
//            wren/bwren/wraddrs/wrdata -> write port, rden/rdaddrs -> read request,
//            rddata/rdvalid/collision  <- read result
module sdp_bram_bytewr_pipe #(
  parameter int unsigned NB_COL      = 128,
  parameter int unsigned COL_WIDTH   = 8,
  parameter int unsigned ADDRS_WIDTH = 12,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WR_FWD      = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  sdp_bram_bytewr_pipe_if.slave bus
);
  localparam int unsigned DataW = NB_COL * COL_WIDTH;
  localparam int unsigned Depth = 2 ** ADDRS_WIDTH;

  // Power-up contents are zero; RESET never touches the array.
  logic [DataW-1:0] mem [Depth] = '{default: '0};

  logic [DataW-1:0] rd_word;
  logic             coll_now;

  logic [DataW-1:0] s1_data_q;
  logic             s1_valid_q;
  logic             s1_coll_q;

  // Write port; anything presented while RESET is high is dropped.
  always_ff @(posedge CLK) begin
    if (!RESET && bus.wren) begin
      for (int i = 0; i < int'(NB_COL); i++) begin
        if (bus.bwren[i]) begin
          mem[bus.wraddrs][i*COL_WIDTH +: COL_WIDTH] <= bus.wrdata[i*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  // Read word with optional write-first merge of the columns being written this cycle.
  always_comb begin
    coll_now = bus.rden && bus.wren && (bus.rdaddrs == bus.wraddrs);
    rd_word  = mem[bus.rdaddrs];
    if ((WR_FWD != 0) && coll_now) begin
      for (int i = 0; i < int'(NB_COL); i++) begin
        if (bus.bwren[i]) begin
          rd_word[i*COL_WIDTH +: COL_WIDTH] = bus.wrdata[i*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  // Stage 1: data holds on idle cycles, flags track the current request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_coll_q  <= 1'b0;
    end else begin
      s1_valid_q <= bus.rden;
      s1_coll_q  <= coll_now;
      if (bus.rden) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign bus.rddata    = s1_data_q;
    assign bus.rdvalid   = s1_valid_q;
    assign bus.collision = s1_coll_q;
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic [DataW-1:0] s2_data_q;
    logic             s2_valid_q;
    logic             s2_coll_q;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
        s2_coll_q  <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_coll_q  <= s1_coll_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign bus.rddata    = s2_data_q;
    assign bus.rdvalid   = s2_valid_q;
    assign bus.collision = s2_coll_q;
  end else begin : g_bad_lat
    $error("sdp_bram_bytewr_pipe: RD_LATENCY must be 1 or 2");
  end
endmodule

// File: tb/tb_sdp_bram_bytewr_pipe.sv
// Directed bench: three instances share one stimulus stream.
//   u_fwd : RD_LATENCY=1, WR_FWD=1
//   u_old : RD_LATENCY=1, WR_FWD=0
//   u_lat2: RD_LATENCY=2, WR_FWD=1
module tb_sdp_bram_bytewr_pipe;
  localparam int unsigned NbCol = 4;
  localparam int unsigned ColW  = 8;
  localparam int unsigned AddrW = 12;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  bwren = '0;
  logic [11:0] wraddrs = '0;
  logic [31:0] wrdata = '0;
  logic        rden = 1'b0;
  logic [11:0] rdaddrs = '0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  sdp_bram_bytewr_pipe_if #(.NB_COL(NbCol), .COL_WIDTH(ColW), .ADDRS_WIDTH(AddrW)) bus_fwd ();
  sdp_bram_bytewr_pipe_if #(.NB_COL(NbCol), .COL_WIDTH(ColW), .ADDRS_WIDTH(AddrW)) bus_old ();
  sdp_bram_bytewr_pipe_if #(.NB_COL(NbCol), .COL_WIDTH(ColW), .ADDRS_WIDTH(AddrW)) bus_lat2 ();

  assign bus_fwd.wren     = wren;
  assign bus_fwd.bwren    = bwren;
  assign bus_fwd.wraddrs  = wraddrs;
  assign bus_fwd.wrdata   = wrdata;
  assign bus_fwd.rden     = rden;
  assign bus_fwd.rdaddrs  = rdaddrs;
  assign bus_old.wren     = wren;
  assign bus_old.bwren    = bwren;
  assign bus_old.wraddrs  = wraddrs;
  assign bus_old.wrdata   = wrdata;
  assign bus_old.rden     = rden;
  assign bus_old.rdaddrs  = rdaddrs;
  assign bus_lat2.wren    = wren;
  assign bus_lat2.bwren   = bwren;
  assign bus_lat2.wraddrs = wraddrs;
  assign bus_lat2.wrdata  = wrdata;
  assign bus_lat2.rden    = rden;
  assign bus_lat2.rdaddrs = rdaddrs;

  sdp_bram_bytewr_pipe #(
    .NB_COL(NbCol), .COL_WIDTH(ColW), .ADDRS_WIDTH(AddrW), .RD_LATENCY(1), .WR_FWD(1)
  ) u_fwd (.CLK(CLK), .RESET(RESET), .bus(bus_fwd));

  sdp_bram_bytewr_pipe #(
    .NB_COL(NbCol), .COL_WIDTH(ColW), .ADDRS_WIDTH(AddrW), .RD_LATENCY(1), .WR_FWD(0)
  ) u_old (.CLK(CLK), .RESET(RESET), .bus(bus_old));

  sdp_bram_bytewr_pipe #(
    .NB_COL(NbCol), .COL_WIDTH(ColW), .ADDRS_WIDTH(AddrW), .RD_LATENCY(2), .WR_FWD(1)
  ) u_lat2 (.CLK(CLK), .RESET(RESET), .bus(bus_lat2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wren = 1'b0; bwren = '0; rden = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    wren = 1'b1; wraddrs = a; wrdata = d; bwren = be; rden = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    wren = 1'b0; bwren = '0; rden = 1'b1; rdaddrs = a;
  endtask

  initial begin
    // Reset state
    #2 RESET = 1'b1;
    cycle(); cycle();
    check_val("rst_fwd_data",   bus_fwd.rddata,     32'h0);
    check_val("rst_fwd_valid",  32'(bus_fwd.rdvalid),   32'h0);
    check_val("rst_fwd_coll",   32'(bus_fwd.collision), 32'h0);
    check_val("rst_lat2_data",  bus_lat2.rddata,    32'h0);
    check_val("rst_lat2_valid", 32'(bus_lat2.rdvalid),  32'h0);
    RESET = 1'b0;
    cycle();

    // Full-word write then read
    wr(12'd5, 32'hDEADBEEF, 4'hF); cycle();
    rd(12'd5); cycle();
    check_val("rd5_fwd_data",   bus_fwd.rddata,           32'hDEADBEEF);
    check_val("rd5_fwd_valid",  32'(bus_fwd.rdvalid),     32'h1);
    check_val("rd5_fwd_coll",   32'(bus_fwd.collision),   32'h0);
    check_val("rd5_old_data",   bus_old.rddata,           32'hDEADBEEF);
    check_val("rd5_lat2_early", 32'(bus_lat2.rdvalid),    32'h0);
    idle(); cycle();
    check_val("rd5_lat2_data",  bus_lat2.rddata,          32'hDEADBEEF);
    check_val("rd5_lat2_valid", 32'(bus_lat2.rdvalid),    32'h1);
    check_val("idle_fwd_valid", 32'(bus_fwd.rdvalid),     32'h0);
    check_val("idle_fwd_hold",  bus_fwd.rddata,           32'hDEADBEEF);

    // Byte-masked write
    wr(12'd5, 32'h11223344, 4'b0101); cycle();
    rd(12'd5); cycle();
    check_val("mask_fwd_data", bus_fwd.rddata, 32'hDE22BE44);
    idle(); cycle();

    // Same-address collision
    wr(12'd7, 32'hAAAAAAAA, 4'hF); cycle();
    wr(12'd7, 32'h55555555, 4'b0011); rden = 1'b1; rdaddrs = 12'd7; cycle();
    check_val("coll_fwd_data", bus_fwd.rddata,         32'hAAAA5555);
    check_val("coll_fwd_flag", 32'(bus_fwd.collision), 32'h1);
    check_val("coll_old_data", bus_old.rddata,         32'hAAAAAAAA);
    check_val("coll_old_flag", 32'(bus_old.collision), 32'h1);
    rd(12'd7); cycle();
    check_val("post_fwd_data",  bus_fwd.rddata,          32'hAAAA5555);
    check_val("post_fwd_flag",  32'(bus_fwd.collision),  32'h0);
    check_val("post_old_data",  bus_old.rddata,          32'hAAAA5555);
    check_val("post_old_flag",  32'(bus_old.collision),  32'h0);
    check_val("coll_lat2_data", bus_lat2.rddata,         32'hAAAA5555);
    check_val("coll_lat2_flag", 32'(bus_lat2.collision), 32'h1);
    idle(); cycle();
    check_val("post_lat2_flag",  32'(bus_lat2.collision), 32'h0);
    check_val("post_lat2_valid", 32'(bus_lat2.rdvalid),   32'h1);

    // Latency-2 back-to-back stream
    wr(12'd0, 32'h10, 4'hF); cycle();
    wr(12'd1, 32'h20, 4'hF); cycle();
    wr(12'd2, 32'h30, 4'hF); cycle();
    rd(12'd0); cycle();
    check_val("stm_clk1_valid", 32'(bus_lat2.rdvalid), 32'h0);
    rd(12'd1); cycle();
    check_val("stm_clk2_valid", 32'(bus_lat2.rdvalid), 32'h1);
    check_val("stm_clk2_data",  bus_lat2.rddata,       32'h10);
    rd(12'd2); cycle();
    check_val("stm_clk3_valid", 32'(bus_lat2.rdvalid), 32'h1);
    check_val("stm_clk3_data",  bus_lat2.rddata,       32'h20);
    idle(); cycle();
    check_val("stm_clk4_valid", 32'(bus_lat2.rdvalid), 32'h1);
    check_val("stm_clk4_data",  bus_lat2.rddata,       32'h30);
    cycle();
    check_val("stm_clk5_valid", 32'(bus_lat2.rdvalid), 32'h0);
    check_val("stm_clk5_hold",  bus_lat2.rddata,       32'h30);

    // Asynchronous reset with a read in flight
    rd(12'd5); cycle();
    #2 RESET = 1'b1;
    #1;
    check_val("arst_lat2_data",  bus_lat2.rddata,      32'h0);
    check_val("arst_lat2_valid", 32'(bus_lat2.rdvalid), 32'h0);
    check_val("arst_fwd_data",   bus_fwd.rddata,       32'h0);
    check_val("arst_fwd_valid",  32'(bus_fwd.rdvalid),  32'h0);
    wr(12'd5, 32'hFFFFFFFF, 4'hF); rden = 1'b1; rdaddrs = 12'd5;
    cycle(); cycle();
    check_val("inrst_lat2_valid", 32'(bus_lat2.rdvalid), 32'h0);
    check_val("inrst_fwd_valid",  32'(bus_fwd.rdvalid),  32'h0);
    RESET = 1'b0; idle(); cycle();
    check_val("rel_lat2_valid", 32'(bus_lat2.rdvalid), 32'h0);
    rd(12'd5); cycle();
    check_val("rel_fwd_data",  bus_fwd.rddata,        32'hDE22BE44);
    check_val("rel_fwd_valid", 32'(bus_fwd.rdvalid),  32'h1);
    idle(); cycle();
    check_val("rel_lat2_data",   bus_lat2.rddata,       32'hDE22BE44);
    check_val("rel_lat2_valid2", 32'(bus_lat2.rdvalid), 32'h1);

    // Address extremes and the all-zero byte-enable no-op
    wr(12'd4095, 32'h0BADF00D, 4'hF); cycle();
    wr(12'd0, 32'h12345678, 4'hF); cycle();
    wr(12'd0, 32'hFFFFFFFF, 4'h0); cycle();
    rd(12'd4095); cycle();
    check_val("max_fwd_data", bus_fwd.rddata, 32'h0BADF00D);
    rd(12'd0); cycle();
    check_val("zero_fwd_data", bus_fwd.rddata, 32'h12345678);
    idle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sdp_bram_bytewr_pipe.md
Name: sdp_bram_bytewr_pipe

Overview:
Parametrised simple dual-port block RAM with per-column (byte) write enables, one write port and one read port on a single clock.
- Generalises the fixed 1024-bit SDP RAM: column count, column width, depth and read latency are configurable.
- Adds a read-valid pipeline, configurable write-to-read collision forwarding and a collision flag.
- Serves as the data-memory and operand-buffer primitive of the compute engine.

Parameters:
NB_COL, 128, number of byte columns per word
COL_WIDTH, 8, bits per column (8 or 9)
ADDRS_WIDTH, 12, address width; depth = 2**ADDRS_WIDTH words
RD_LATENCY, 1, read latency in clocks, legal values 1 or 2
WR_FWD, 1, 1 = write-first forwarding on same-address collision; 0 = read-first (old data)

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous active-high reset
wren  input  1  write enable
bwren  input  NB_COL  per-column write enable, qualified by wren
wraddrs  input  ADDRS_WIDTH  write address
wrdata  input  NB_COL*COL_WIDTH  write data
rden  input  1  read request
rdaddrs  input  ADDRS_WIDTH  read address
rddata  output  NB_COL*COL_WIDTH  read data
rdvalid  output  1  rddata holds the result of a request issued RD_LATENCY clocks earlier
collision  output  1  result on rddata came from a same-address read/write cycle; aligned with rdvalid

Behaviour:
- Memory array is initialised to all zeros at time zero and is never cleared by RESET.
- Write: on a CLK edge with wren=1 and RESET=0, column i of word wraddrs is updated from wrdata column i when bwren[i]=1. Columns with bwren[i]=0 are unchanged. wren=1 with bwren all zero is a no-op.
- Read stage 1: on a CLK edge with rden=1 and RESET=0, the stage-1 data register loads word rdaddrs and the stage-1 valid flag sets.
  - With rden=0, the stage-1 data register holds its value and the stage-1 valid flag clears.
  - Unlike the previous generation, wren alone does not update read data.
- Collision: a cycle with rden=1, wren=1 and rdaddrs==wraddrs.
  - WR_FWD=1: column i of the loaded word is wrdata column i where bwren[i]=1; other columns are the pre-write memory contents.
  - WR_FWD=0: the whole loaded word is the pre-write contents.
  - Either mode: the stage-1 collision flag sets. A non-collision read clears it.
- RD_LATENCY=1: rddata, rdvalid and collision are driven directly by the stage-1 registers.
- RD_LATENCY=2:
  - The stage-2 data register loads from stage 1 only when the stage-1 valid flag is set, and otherwise holds.
  - The stage-2 valid and collision flags copy stage 1 every cycle.
  - Outputs are driven from stage 2.
- Back-to-back reads every cycle give one result per cycle. rddata holds the last result while rdvalid=0.
- RESET asserted, at any time and asynchronously:
  - All data registers clear to 0 and rdvalid=0, collision=0.
  - Reads in flight are discarded.
  - Writes and reads presented while RESET=1 are ignored.
  - After deassertion, the first valid result appears RD_LATENCY clocks after the first accepted rden.
- Address wrap: addresses are ADDRS_WIDTH bits; no out-of-range condition exists.
- A RD_LATENCY value other than 1 or 2 is a configuration error, flagged by an elaboration-time check.
- Reset values: rddata=0, rdvalid=0, collision=0.

Test Plan:
1. NB_COL=4, COL_WIDTH=8, RD_LATENCY=1: write 0xDEADBEEF to addr 5 (bwren=4'hF), then rden addr 5 -> next clock rddata=0xDEADBEEF, rdvalid=1, collision=0.
2. Byte mask: over addr 5 (0xDEADBEEF), write 0x11223344 with bwren=4'b0101, then read -> 0xDE22BE44.
3. Collision, WR_FWD=1: addr 7 holds 0xAAAAAAAA; same cycle write 0x55555555 bwren=4'b0011 and read addr 7 -> rddata=0xAAAA5555, collision=1. With WR_FWD=0 -> rddata=0xAAAAAAAA, collision=1. Following read of addr 7 -> 0xAAAA5555, collision=0.
4. RD_LATENCY=2, reads of addrs 0,1,2 on consecutive cycles (preloaded 0x10,0x20,0x30) -> rdvalid high on clocks 2,3,4 after the first request with data 0x10,0x20,0x30; rden then low -> rdvalid=0 and rddata holds 0x30.
5. Reset mid-operation: RD_LATENCY=2, issue a read, assert RESET asynchronously between edges -> rddata=0, rdvalid=0 immediately, no valid result appears. A write issued during RESET is not stored. Earlier contents of addr 5 still read back after release.
6. Max address: ADDRS_WIDTH=12, write 0x0BADF00D to addr 4095 and 0x12345678 to addr 0 -> each reads back unchanged, with no aliasing between the two.
